// File: rtl/uart_rx_sipo.sv
// UART receive stage: synchronizes rx_in, samples start/data/parity/stop at mid-bit and
// presents each character with parity/framing flags one clk after the last stop sample.
module uart_rx_sipo #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       rx_in,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       rx_active
);

  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2 - 1;
  localparam logic [TW-1:0] MID_T  = TW'(MID);
  localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] ONE_T  = TW'(1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_bit_q, par_bit_d;
  logic          ferr_acc_q, ferr_acc_d;
  logic [1:0]    cfg_par_q, cfg_par_d;
  logic          cfg_stop_q, cfg_stop_d;
  logic          cfg_len_q, cfg_len_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          active_q, active_d;

  logic rxs, par_en, bit_end, par_x, ferr_now;

  assign rxs      = sync2_q;
  assign par_en   = (cfg_par_q == 2'b01) || (cfg_par_q == 2'b10);
  assign bit_end  = (tick_q == LAST_T);
  assign par_x    = (^shift_q) ^ par_bit_q;
  assign ferr_now = ferr_acc_q | ~rxs;

  always_comb begin
    sync1_d      = rx_in;
    sync2_d      = sync1_q;
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    ferr_acc_d   = ferr_acc_q;
    cfg_par_d    = cfg_par_q;
    cfg_stop_d   = cfg_stop_q;
    cfg_len_d    = cfg_len_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    active_d     = active_q;

    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d    = START;
            tick_d     = '0;
            cfg_par_d  = parity_type;
            cfg_stop_d = stop_bits;
            cfg_len_d  = data_length;
          end
        end
        START: begin
          if (tick_q == MID_T) begin
            if (rxs) begin
              state_d = IDLE;
            end else begin
              state_d    = DATA;
              active_d   = 1'b1;
              tick_d     = '0;
              bit_d      = '0;
              shift_d    = '0;
              ferr_acc_d = 1'b0;
            end
          end else begin
            tick_d = tick_q + ONE_T;
          end
        end
        DATA: begin
          if (bit_end) begin
            tick_d         = '0;
            shift_d[bit_q] = rxs;
            // last index is 6 or 7 depending on the latched length
            if (bit_q == {2'b11, cfg_len_q}) begin
              bit_d   = '0;
              state_d = par_en ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + ONE_T;
          end
        end
        PARITY: begin
          if (bit_end) begin
            tick_d    = '0;
            par_bit_d = rxs;
            state_d   = STOP;
          end else begin
            tick_d = tick_q + ONE_T;
          end
        end
        STOP: begin
          if (bit_end) begin
            tick_d = '0;
            if (cfg_stop_q && (bit_q == 3'd0)) begin
              bit_d      = 3'd1;
              ferr_acc_d = ferr_now;
            end else begin
              data_out_d   = {shift_q[7] & cfg_len_q, shift_q[6:0]};
              data_valid_d = 1'b1;
              perr_d       = par_en & (cfg_par_q[0] ? ~par_x : par_x);
              ferr_d       = ferr_now;
              active_d     = 1'b0;
              state_d      = rxs ? IDLE : WAIT_HIGH;
            end
          end else begin
            tick_d = tick_q + ONE_T;
          end
        end
        WAIT_HIGH: begin
          if (rxs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      ferr_acc_q   <= 1'b0;
      cfg_par_q    <= '0;
      cfg_stop_q   <= 1'b0;
      cfg_len_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      ferr_acc_q   <= ferr_acc_d;
      cfg_par_q    <= cfg_par_d;
      cfg_stop_q   <= cfg_stop_d;
      cfg_len_q    <= cfg_len_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      active_q     <= active_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign rx_active     = active_q;

endmodule
